// File: rtl/vram_fill_dma_if.sv
// Shared data-memory bus: CPU request in, arbitrated dmem port out.
// The DMA block takes the master view; whoever drives the CPU side and observes dmem takes the slave view.
interface vram_fill_dma_if;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_a;
    logic [31:0] cpu_wd;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;

    modport master (
        input  cpu_we, cpu_re, cpu_a, cpu_wd,
        output mem_we, mem_a, mem_wd
    );

    modport slave (
        output cpu_we, cpu_re, cpu_a, cpu_wd,
        input  mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/vram_fill_dma.sv
// VRAM fill engine: writes one 32-bit word per free cycle into the VRAM window (bit 14 of the address).
// The CPU always wins the shared memory port; a DMA cycle lost to the CPU is simply retried.
module vram_fill_dma #(
    parameter int VRAM_WORDS = 2400
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [11:0]            base,
    input  logic [11:0]            count,
    input  logic [31:0]            value,
    input  logic                   abort,
    vram_fill_dma_if.master        bus,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] idx_q, idx_d;
    logic [11:0] rem_q, rem_d;
    logic [31:0] val_q, val_d;
    logic        err_q, err_d;

    logic        cpu_own;
    logic        dma_wr;
    logic [12:0] end_w;
    logic        fill_ok;

    assign cpu_own = bus.cpu_we | bus.cpu_re;
    assign dma_wr  = (state_q == FILL) && !cpu_own;

    // 13-bit sum so base+count can never wrap past the VRAM size
    assign end_w   = {1'b0, base} + {1'b0, count};
    assign fill_ok = (count != 12'd0) && (end_w <= 13'(VRAM_WORDS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 12'd0;
            rem_q   <= 12'd0;
            val_q   <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            val_q   <= val_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        val_d   = val_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (fill_ok) begin
                        state_d = FILL;
                        idx_d   = base;
                        rem_d   = count;
                        val_d   = value;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FILL: begin
                if (dma_wr) begin
                    // idx is held on the last word so it never points past the end of VRAM
                    if (rem_q == 12'd1) begin
                        state_d = FINISH;
                        rem_d   = 12'd0;
                    end else begin
                        idx_d = idx_q + 12'd1;
                        rem_d = rem_q - 12'd1;
                    end
                end
                if (abort) begin
                    state_d = IDLE;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.mem_we = cpu_own ? bus.cpu_we : dma_wr;
        bus.mem_a  = dma_wr ? {17'd0, 1'b1, 2'd0, idx_q} : bus.cpu_a;
        bus.mem_wd = dma_wr ? val_q : bus.cpu_wd;
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == FINISH) && !abort;
    assign err  = err_q;

endmodule

// File: tb/tb_vram_fill_dma.sv
// Directed bench for vram_fill_dma: normal fill, CPU contention, bounds, abort, reset and restart.
module tb_vram_fill_dma;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] base;
    logic [11:0] count;
    logic [31:0] value;
    logic        abort;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    vram_fill_dma_if bus ();

    vram_fill_dma #(.VRAM_WORDS(2400)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .base  (base),
        .count (count),
        .value (value),
        .abort (abort),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance past the next rising edge; caller then drives inputs and waits #1 before checking
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic [31:0] a, input logic [31:0] d);
        check({tag, ".we"}, {31'd0, bus.mem_we}, 32'd1);
        check({tag, ".a"}, bus.mem_a, a);
        check({tag, ".wd"}, bus.mem_wd, d);
        check({tag, ".busy"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic chk_done(input string tag);
        check({tag, ".done"}, {31'd0, done}, 32'd1);
        check({tag, ".busy"}, {31'd0, busy}, 32'd1);
        check({tag, ".we"}, {31'd0, bus.mem_we}, 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        check({tag, ".busy"}, {31'd0, busy}, 32'd0);
        check({tag, ".done"}, {31'd0, done}, 32'd0);
        check({tag, ".we"}, {31'd0, bus.mem_we}, 32'd0);
    endtask

    // raise start for one edge; returns in cycle N+1 with inputs settled
    task automatic launch(input logic [11:0] b, input logic [11:0] c, input logic [31:0] v);
        cyc();
        start = 1'b1; base = b; count = c; value = v;
        #1;
        cyc();
        start = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base = '0; count = '0; value = '0; abort = 1'b0;
        bus.cpu_we = 1'b0; bus.cpu_re = 1'b0; bus.cpu_a = 32'h0000_0100; bus.cpu_wd = 32'h0000_0200;
        #2;
        chk_idle("rst");
        check("rst.err", {31'd0, err}, 32'd0);
        check("rst.pass_a", bus.mem_a, 32'h0000_0100);
        cyc(); cyc();
        rst_n = 1'b1;

        // idle CPU: base 0, count 4
        launch(12'd0, 12'd4, 32'hA5A5_A5A5);
        for (int i = 0; i < 4; i++) begin
            chk_wr("fill4", 32'h4000 + i, 32'hA5A5_A5A5);
            check("fill4.done", {31'd0, done}, 32'd0);
            cyc(); #1;
        end
        chk_done("fill4.fin");
        cyc(); #1;
        chk_idle("fill4.after");

        // CPU contention: reads in N+2..N+3 stall the fill
        launch(12'd10, 12'd3, 32'h1111_2222);
        chk_wr("cont.n1", 32'h400A, 32'h1111_2222);
        cyc();
        bus.cpu_re = 1'b1; bus.cpu_a = 32'h0000_1234; bus.cpu_wd = 32'h0000_0BEE;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("cont.cpu_we", {31'd0, bus.mem_we}, 32'd0);
            check("cont.cpu_a", bus.mem_a, 32'h0000_1234);
            check("cont.cpu_wd", bus.mem_wd, 32'h0000_0BEE);
            check("cont.busy", {31'd0, busy}, 32'd1);
            cyc();
        end
        bus.cpu_re = 1'b0;
        #1;
        chk_wr("cont.n4", 32'h400B, 32'h1111_2222);
        cyc(); #1;
        chk_wr("cont.n5", 32'h400C, 32'h1111_2222);
        cyc(); #1;
        chk_done("cont.fin");
        cyc(); #1;
        chk_idle("cont.after");

        // CPU write during FILL passes straight through
        launch(12'd7, 12'd2, 32'hCAFE_0001);
        bus.cpu_we = 1'b1; bus.cpu_a = 32'h0000_0044; bus.cpu_wd = 32'h0000_0055;
        #1;
        check("cpuwr.we", {31'd0, bus.mem_we}, 32'd1);
        check("cpuwr.a", bus.mem_a, 32'h0000_0044);
        check("cpuwr.wd", bus.mem_wd, 32'h0000_0055);
        cyc();
        bus.cpu_we = 1'b0;
        #1;
        chk_wr("cpuwr.d0", 32'h4007, 32'hCAFE_0001);
        cyc(); #1;
        chk_wr("cpuwr.d1", 32'h4008, 32'hCAFE_0001);
        cyc(); #1;
        chk_done("cpuwr.fin");

        // bounds: last word accepted
        launch(12'd2399, 12'd1, 32'h0F0F_0F0F);
        chk_wr("b2399", 32'h495F, 32'h0F0F_0F0F);
        cyc(); #1;
        chk_done("b2399.fin");

        // bounds: one past the end rejected
        launch(12'd2399, 12'd2, 32'h1);
        check("bover.err", {31'd0, err}, 32'd1);
        chk_idle("bover");
        cyc(); #1;
        check("bover.err_clr", {31'd0, err}, 32'd0);
        chk_idle("bover2");

        // bounds: zero count rejected
        launch(12'd5, 12'd0, 32'h2);
        check("zero.err", {31'd0, err}, 32'd1);
        chk_idle("zero");

        // abort in N+5 of a 100-word fill
        launch(12'd100, 12'd100, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            chk_wr("abort.w", 32'h4064 + i, 32'hDEAD_BEEF);
            cyc(); #1;
        end
        abort = 1'b1;
        #1;
        chk_wr("abort.last", 32'h4068, 32'hDEAD_BEEF);
        check("abort.nodone", {31'd0, done}, 32'd0);
        cyc();
        abort = 1'b0;
        #1;
        chk_idle("abort.after");

        // new start accepted after abort, with abort also high (start wins)
        cyc();
        start = 1'b1; abort = 1'b1; base = 12'd1; count = 12'd1; value = 32'h7777_8888;
        #1;
        cyc();
        start = 1'b0; abort = 1'b0;
        #1;
        check("sa.err", {31'd0, err}, 32'd0);
        chk_wr("sa.w", 32'h4001, 32'h7777_8888);
        cyc(); #1;
        chk_done("sa.fin");

        // second start during FILL is ignored
        launch(12'd20, 12'd3, 32'h0000_00A1);
        chk_wr("dbl.n1", 32'h4014, 32'h0000_00A1);
        cyc();
        start = 1'b1; base = 12'd30; count = 12'd2; value = 32'h0000_00B2;
        #1;
        chk_wr("dbl.n2", 32'h4015, 32'h0000_00A1);
        cyc();
        start = 1'b0;
        #1;
        check("dbl.err", {31'd0, err}, 32'd0);
        chk_wr("dbl.n3", 32'h4016, 32'h0000_00A1);
        cyc(); #1;
        chk_done("dbl.fin");
        cyc(); #1;
        chk_idle("dbl.after");

        // reset mid-fill at N+3 of a 50-word fill
        launch(12'd0, 12'd50, 32'h5A5A_5A5A);
        chk_wr("rstf.n1", 32'h4000, 32'h5A5A_5A5A);
        cyc(); #1;
        chk_wr("rstf.n2", 32'h4001, 32'h5A5A_5A5A);
        cyc();
        bus.cpu_we = 1'b1; bus.cpu_a = 32'h0000_0055; bus.cpu_wd = 32'h0000_0066;
        rst_n = 1'b0;
        #1;
        check("rstf.busy", {31'd0, busy}, 32'd0);
        check("rstf.we", {31'd0, bus.mem_we}, 32'd1);
        check("rstf.a", bus.mem_a, 32'h0000_0055);
        bus.cpu_we = 1'b0;
        #1;
        check("rstf.we0", {31'd0, bus.mem_we}, 32'd0);
        cyc();
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk_idle("rstf.post");
            cyc(); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vram_fill_dma.md
VRAM_FILL_DMA -- requirements
Module: vram_fill_dma

Interface
REQ-001 The block SHALL have parameter VRAM_WORDS, default 2400, giving the number of 32-bit tile words in VRAM.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: one-cycle fill request.
REQ-005 The block SHALL have port base, input, 12 bits: first tile index of the fill.
REQ-006 The block SHALL have port count, input, 12 bits: number of words to write.
REQ-007 The block SHALL have port value, input, 32 bits: fill word.
REQ-008 The block SHALL have port abort, input, 1 bit: cancel the fill in progress.
REQ-009 The block SHALL have ports cpu_we (input, 1), cpu_re (input, 1), cpu_a (input, 32) and cpu_wd (input, 32): the CPU data-memory request.
REQ-010 The block SHALL have ports mem_we (output, 1), mem_a (output, 32) and mem_wd (output, 32): the shared data-memory port driven into dmem.
REQ-011 The block SHALL have outputs busy (1 bit), done (1 bit, one-cycle pulse) and err (1 bit, one-cycle pulse).

Function
REQ-012 The block SHALL implement states IDLE, FILL and FINISH.
REQ-013 In IDLE, a start with 1 <= count and base+count <= VRAM_WORDS SHALL latch base, count and value, and enter FILL on the next edge.
REQ-014 A start in IDLE with count==0, or with base+count > VRAM_WORDS (computed at 13 bits, no truncation), SHALL pulse err for one cycle and stay in IDLE.
REQ-015 A start while not in IDLE SHALL be ignored: no err, and the latched values are unchanged.
REQ-016 The CPU SHALL have absolute priority: whenever cpu_we or cpu_re is 1, mem_we=cpu_we, mem_a=cpu_a and mem_wd=cpu_wd, combinationally, in every state.
REQ-017 In FILL, in a cycle with cpu_we=0 and cpu_re=0, the block SHALL drive mem_we=1, mem_a={17'b0,1'b1,2'b0,idx[11:0]} (bit 14 set, selecting VRAM) and mem_wd=value_latched.
REQ-018 In such a write cycle the block SHALL increment idx and decrement the remaining count.
REQ-019 A FILL cycle in which the CPU owns the port SHALL be a stall: idx and the remaining count are unchanged, and no write is lost or duplicated.
REQ-020 When neither the CPU nor the DMA owns the port, the block SHALL drive mem_we=0, mem_a=cpu_a and mem_wd=cpu_wd.
REQ-021 After the write with remaining count==1, the block SHALL enter FINISH.
REQ-022 FINISH SHALL last one cycle, pulse done=1 and return to IDLE.
REQ-023 busy SHALL be 1 in FILL and FINISH and 0 in IDLE.
REQ-024 Fill latency with an idle CPU SHALL be: start at edge N, first write in cycle N+1, last write in cycle N+count, done in cycle N+count+1.
REQ-025 abort=1 in FILL or FINISH SHALL return the block to IDLE on the next edge with no done pulse.
REQ-026 In the abort cycle the block SHALL still perform that cycle's DMA write if it owns the port.
REQ-027 If abort and start are both 1 in IDLE, start SHALL win and abort is ignored.
REQ-028 idx SHALL never exceed VRAM_WORDS-1, and no address wrap-around is permitted (guaranteed by REQ-014).

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, clear idx, remaining count and the latched value to 0, and drive busy=0, done=0 and err=0.
REQ-030 During reset the memory-port outputs SHALL follow REQ-016 and REQ-020 (CPU passthrough, no DMA write).
REQ-031 Reset asserted mid-FILL SHALL abandon the fill; after release the block SHALL be in IDLE, awaiting a new start.

Verification
REQ-032 Idle CPU: base=0, count=4, value=0xA5A5A5A5 -> writes to 0x4000, 0x4001, 0x4002, 0x4003 in cycles N+1..N+4, done pulse at N+5, busy high N+1..N+5.
REQ-033 CPU contention: base=10, count=3, cpu_re=1 in cycles N+2..N+3 -> DMA writes at 0x400A (N+1), 0x400B (N+4), 0x400C (N+5); CPU address is visible on mem_a in N+2..N+3; done at N+6.
REQ-034 Bounds: base=2399, count=1 -> one write at 0x495F then done; base=2399, count=2 -> err pulse, busy stays 0, no write; count=0 -> err pulse.
REQ-035 Abort: count=100, abort in cycle N+5 -> five writes (0x4000+base .. +4), IDLE at N+6, no done; a new start is then accepted.
REQ-036 Reset: rst_n low in cycle N+3 of a count=50 fill -> busy drops without waiting for a clock edge, mem_we follows cpu_we, no further DMA writes after release.
REQ-037 A second start during FILL -> ignored; the original fill completes with its own base, count and value.
